// File: rtl/etapa_operandos_if.sv
// Instruction, output-stage and write-back signals of the operand-fetch stage.
// master drives instructions, out_ready and write-back; slave is the stage itself.
interface etapa_operandos_if #(
  parameter int W  = 16,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] AA;
  logic [AW-1:0] BA;
  logic          MB;
  logic [W-1:0]  const_in;
  logic [3:0]    FS_in;
  logic [AW-1:0] DA_in;
  logic          RW_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  A_out;
  logic [W-1:0]  B_out;
  logic [3:0]    FS_out;
  logic [AW-1:0] DA_out;
  logic          RW_out;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [3:0]    wb_flags;
  logic [3:0]    flags;

  modport master (
    output in_valid, AA, BA, MB, const_in, FS_in, DA_in, RW_in,
    output out_ready, wb_en, wb_addr, wb_data, wb_flags,
    input  in_ready, out_valid, A_out, B_out, FS_out, DA_out, RW_out, flags
  );

  modport slave (
    input  in_valid, AA, BA, MB, const_in, FS_in, DA_in, RW_in,
    input  out_ready, wb_en, wb_addr, wb_data, wb_flags,
    output in_ready, out_valid, A_out, B_out, FS_out, DA_out, RW_out, flags
  );
endinterface

// File: rtl/etapa_operandos.sv
// Operand-fetch stage: register file with write-back bypass, pending-write
// scoreboard for RAW stalls, and a single valid/ready output register stage.
module etapa_operandos #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input logic               clk,
  input logic               rst_n,
  etapa_operandos_if.slave  bus
);
  logic [W-1:0]    rf [NREG];
  logic [NREG-1:0] pend;

  logic          out_valid_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [3:0]    fs_q;
  logic [AW-1:0] da_q;
  logic          rw_q;
  logic [3:0]    flags_q;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] b_sel;
  logic         byp_a;
  logic         byp_b;
  logic         haz_a;
  logic         haz_b;
  logic         ready;
  logic         accept;

  always_comb begin
    byp_a  = bus.wb_en && (bus.wb_addr == bus.AA);
    byp_b  = bus.wb_en && (bus.wb_addr == bus.BA);
    op_a   = byp_a ? bus.wb_data : rf[bus.AA];
    op_b   = byp_b ? bus.wb_data : rf[bus.BA];
    b_sel  = bus.MB ? bus.const_in : op_b;
    // A write-back landing this cycle resolves the hazard via the bypass path.
    haz_a  = pend[bus.AA] && !byp_a;
    haz_b  = !bus.MB && pend[bus.BA] && !byp_b;
    ready  = (!out_valid_q || bus.out_ready) && !(haz_a || haz_b);
    accept = bus.in_valid && ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) rf[AW'(r)] <= '0;
      pend        <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      fs_q        <= '0;
      da_q        <= '0;
      rw_q        <= 1'b0;
      flags_q     <= '0;
    end else begin
      if (bus.wb_en) begin
        rf[bus.wb_addr] <= bus.wb_data;
        flags_q         <= bus.wb_flags;
      end
      // Set beats clear: a newly accepted writer keeps its destination pending.
      for (int unsigned r = 0; r < NREG; r++) begin
        if (accept && bus.RW_in && (bus.DA_in == AW'(r)))
          pend[AW'(r)] <= 1'b1;
        else if (bus.wb_en && (bus.wb_addr == AW'(r)))
          pend[AW'(r)] <= 1'b0;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        a_q         <= op_a;
        b_q         <= b_sel;
        fs_q        <= bus.FS_in;
        da_q        <= bus.DA_in;
        rw_q        <= bus.RW_in;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.A_out     = a_q;
  assign bus.B_out     = b_q;
  assign bus.FS_out    = fs_q;
  assign bus.DA_out    = da_q;
  assign bus.RW_out    = rw_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_etapa_operandos.sv
// Directed bench for etapa_operandos: a per-cycle reference model plus
// hand-computed literal checks on each scenario.
module tb_etapa_operandos;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  etapa_operandos_if #(.W(16), .AW(3)) bus ();

  etapa_operandos #(.W(16), .NREG(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: register file, pending set, and one output slot.
  logic [15:0] m_rf [8];
  logic [7:0]  m_pend;
  logic        m_ov;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_fs, m_flags;
  logic [2:0]  m_da;
  logic        m_rw;

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_rf[a];
  endfunction

  function automatic logic m_ready();
    logic wait_a, wait_b;
    wait_a = m_pend[bus.AA] && !(bus.wb_en && bus.wb_addr == bus.AA);
    wait_b = !bus.MB && m_pend[bus.BA] && !(bus.wb_en && bus.wb_addr == bus.BA);
    return (!m_ov || bus.out_ready) && !wait_a && !wait_b;
  endfunction

  always @(posedge clk) begin
    logic acc;
    logic [15:0] va, vb;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      m_pend = 8'h0; m_ov = 1'b0; m_a = 16'h0; m_b = 16'h0;
      m_fs = 4'h0; m_da = 3'h0; m_rw = 1'b0; m_flags = 4'h0;
    end else begin
      acc = bus.in_valid && m_ready();
      va  = m_read(bus.AA);
      vb  = bus.MB ? bus.const_in : m_read(bus.BA);
      if (bus.wb_en) begin
        m_rf[bus.wb_addr]   = bus.wb_data;
        m_flags             = bus.wb_flags;
        m_pend[bus.wb_addr] = 1'b0;
      end
      if (acc && bus.RW_in) m_pend[bus.DA_in] = 1'b1;
      if (acc) begin
        m_ov = 1'b1; m_a = va; m_b = vb; m_fs = bus.FS_in; m_da = bus.DA_in; m_rw = bus.RW_in;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_in_ready", 32'(bus.in_ready), 32'(m_ready()));
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("model_A_out", 32'(bus.A_out), 32'(m_a));
      chk("model_B_out", 32'(bus.B_out), 32'(m_b));
      chk("model_FS_out", 32'(bus.FS_out), 32'(m_fs));
      chk("model_DA_out", 32'(bus.DA_out), 32'(m_da));
      chk("model_RW_out", 32'(bus.RW_out), 32'(m_rw));
      chk("model_flags", 32'(bus.flags), 32'(m_flags));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.AA = '0; bus.BA = '0; bus.MB = 1'b1;
    bus.const_in = '0; bus.FS_in = '0; bus.DA_in = '0; bus.RW_in = 1'b0;
    bus.out_ready = 1'b1; bus.wb_en = 1'b0; bus.wb_addr = '0;
    bus.wb_data = '0; bus.wb_flags = '0;
  endtask

  task automatic issue(input logic [2:0] aa, input logic [2:0] ba, input logic mb,
                       input logic [15:0] k, input logic [3:0] fs,
                       input logic [2:0] da, input logic rw);
    bus.in_valid = 1'b1; bus.AA = aa; bus.BA = ba; bus.MB = mb;
    bus.const_in = k; bus.FS_in = fs; bus.DA_in = da; bus.RW_in = rw;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d, input logic [3:0] f);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d; bus.wb_flags = f;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);
    chk("rst_A_out", 32'(bus.A_out), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;

    // 1: write-back to R3, then read it against a constant B.
    wb(3'd3, 16'h1234, 4'h0);
    tick(); idle();
    issue(3'd3, 3'd0, 1'b1, 16'h0005, 4'b0010, 3'd0, 1'b0);
    tick(); idle();
    chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_A_out", 32'(bus.A_out), 32'h1234);
    chk("t1_B_out", 32'(bus.B_out), 32'h0005);
    chk("t1_FS_out", 32'(bus.FS_out), 32'h2);

    // 2: RAW stall on R2, released by a bypassed write-back.
    issue(3'd0, 3'd0, 1'b1, 16'h0, 4'h1, 3'd2, 1'b1);
    tick(); idle();
    issue(3'd2, 3'd0, 1'b1, 16'h0, 4'h3, 3'd0, 1'b0);
    #1 chk("t2_stall0", 32'(bus.in_ready), 32'h0);
    tick();
    chk("t2_stall1", 32'(bus.in_ready), 32'h0);
    wb(3'd2, 16'h00FF, 4'h0);
    #1 chk("t2_release", 32'(bus.in_ready), 32'h1);
    tick(); idle();
    chk("t2_bypass_A", 32'(bus.A_out), 32'h00FF);

    // 3: downstream backpressure holds outputs stable.
    issue(3'd3, 3'd0, 1'b1, 16'h0AAA, 4'h5, 3'd0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    issue(3'd2, 3'd0, 1'b1, 16'h0BBB, 4'h7, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_A", 32'(bus.A_out), 32'h1234);
      chk("t3_hold_B", 32'(bus.B_out), 32'h0AAA);
      chk("t3_hold_FS", 32'(bus.FS_out), 32'h5);
      chk("t3_hold_rdy", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1 chk("t3_rdy_up", 32'(bus.in_ready), 32'h1);
    tick(); idle();
    chk("t3_new_A", 32'(bus.A_out), 32'h00FF);
    chk("t3_new_B", 32'(bus.B_out), 32'h0BBB);
    chk("t3_new_DA", 32'(bus.DA_out), 32'h1);

    // 4: constant B ignores a pending BA.
    issue(3'd0, 3'd0, 1'b1, 16'h0, 4'h0, 3'd5, 1'b1);
    tick(); idle();
    issue(3'd0, 3'd5, 1'b1, 16'h0C0C, 4'h9, 3'd0, 1'b0);
    #1 chk("t4_no_stall", 32'(bus.in_ready), 32'h1);
    tick(); idle();
    chk("t4_B_const", 32'(bus.B_out), 32'h0C0C);
    wb(3'd5, 16'h5555, 4'h0);
    tick(); idle();

    // 5: accept-set wins over same-cycle write-back clear.
    issue(3'd0, 3'd0, 1'b1, 16'h0, 4'h0, 3'd4, 1'b1);
    wb(3'd4, 16'h4444, 4'h0);
    tick(); idle();
    issue(3'd4, 3'd0, 1'b1, 16'h0, 4'h0, 3'd0, 1'b0);
    #1 chk("t5_stall0", 32'(bus.in_ready), 32'h0);
    tick();
    chk("t5_stall1", 32'(bus.in_ready), 32'h0);
    wb(3'd4, 16'h4AAA, 4'h0);
    tick(); idle();
    chk("t5_A_out", 32'(bus.A_out), 32'h4AAA);

    // 6: flags latch, then reset while stalled.
    wb(3'd6, 16'h6666, 4'b0110);
    tick(); idle();
    chk("t6_flags", 32'(bus.flags), 32'h6);
    issue(3'd0, 3'd0, 1'b1, 16'h0, 4'h0, 3'd1, 1'b1);
    tick(); idle();
    issue(3'd1, 3'd0, 1'b1, 16'h0, 4'h0, 3'd0, 1'b0);
    tick();
    chk("t6_stalled", 32'(bus.in_ready), 32'h0);
    rst_n = 1'b0; idle();
    tick();
    rst_n = 1'b1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_rst_flags", 32'(bus.flags), 32'h0);
    chk("t6_rst_ready", 32'(bus.in_ready), 32'h1);
    for (int r = 0; r < 8; r++) begin
      issue(3'(r), 3'(r), 1'b0, 16'h0, 4'h0, 3'd0, 1'b0);
      tick();
      chk("t6_regA_zero", 32'(bus.A_out), 32'h0);
      chk("t6_regB_zero", 32'(bus.B_out), 32'h0);
    end
    idle();
    wb(3'd7, 16'h7777, 4'b1001);
    tick(); idle();
    issue(3'd7, 3'd7, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0);
    tick(); idle();
    chk("t6_post_wb", 32'(bus.A_out), 32'h7777);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/etapa_operandos.md
Name: etapa_operandos

Overview:
- Operand-fetch stage directly upstream of unidad_funcional.
- Holds an 8x16 register file and reads two operands, selecting the B operand as either a register or a constant.
- Registers the operands with FS and destination information into a single output stage, using a valid/ready handshake.
- Tracks pending writes with a scoreboard and stalls on RAW hazards.
- Accepts write-back of the FU result and latches the FU status flags V, Z, N, C.

Parameters:
- W, 16, datapath width; must match unidad_funcional.
- NREG, 8, number of registers.
- AW, 3, register address width; NREG = 2**AW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage accepts instruction this cycle.
- AA  in  AW  A operand register address.
- BA  in  AW  B operand register address.
- MB  in  1  1 = B operand is const_in, 0 = register BA.
- const_in  in  W  constant operand.
- FS_in  in  4  function select passed to the FU.
- DA_in  in  AW  destination register.
- RW_in  in  1  instruction writes DA.
- out_valid  out  1  output stage holds a valid instruction.
- out_ready  in  1  downstream consumes this cycle.
- A_out  out  W  operand A to the FU.
- B_out  out  W  operand B to the FU.
- FS_out  out  4  registered FS.
- DA_out  out  AW  registered destination.
- RW_out  out  1  registered write enable.
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back register.
- wb_data  in  W  write-back value (FU F).
- wb_flags  in  4  {V,Z,N,C} from the FU.
- flags  out  4  latched {V,Z,N,C}.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all registers become 0.
  - scoreboard clears.
  - out_valid=0; A_out, B_out, FS_out, DA_out, RW_out = 0.
  - flags=0.
  - Reset mid-stall discards the held instruction; in-flight write-backs arriving after reset still write normally.
- Write port:
  - when wb_en=1, reg[wb_addr] <= wb_data and flags <= wb_flags at the edge.
  - R0 is an ordinary register.
- Read with bypass:
  - opA = (wb_en && wb_addr==AA) ? wb_data : reg[AA].
  - opB is formed the same way from BA.
  - B_sel = MB ? const_in : opB.
- Scoreboard: pend[NREG], one bit per register.
  - hazA = pend[AA] && !(wb_en && wb_addr==AA).
  - hazB = !MB && pend[BA] && !(wb_en && wb_addr==BA).
  - stall = hazA || hazB.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !stall.
  - accept = in_valid && in_ready; the output registers load opA, B_sel, FS_in, DA_in, RW_in, and out_valid <= 1.
  - if !accept && out_ready, out_valid <= 0.
  - while out_valid && !out_ready, all outputs hold stable.
  - latency: 1 cycle, accept to out_valid.
  - throughput: 1 per cycle when there is no hazard and out_ready=1.
- Scoreboard update, per register r:
  - set if accept && RW_in && DA_in==r.
  - clear if wb_en && wb_addr==r.
  - simultaneous set and clear on the same r: set wins, because the new write is outstanding.
- The hazard check uses the registered pend bits only. An instruction whose destination equals its own source does not stall itself.
- Held output operands are captured at accept and are not refreshed by later write-backs. The scoreboard guarantees correctness.
- The interface does not detect write-backs to non-pending registers; they write normally.

Test Plan:
1. Reset, then a write-back to R3 with 16'h1234, then issue AA=3, MB=1, const_in=16'h0005, FS=4'b0010 -> next cycle out_valid=1, A_out=16'h1234, B_out=16'h0005, FS_out=4'b0010.
2. Issue a write to DA=2 (RW=1), then next cycle issue with AA=2 and no write-back -> in_ready=0 until wb_en with wb_addr=2 and 16'h00FF. In that same cycle in_ready=1 and the next cycle A_out=16'h00FF (bypass).
3. out_ready=0 with out_valid=1, change the inputs -> all outputs are unchanged for 3 cycles, and in_ready=0. Raise out_ready -> the queued instruction loads in the same cycle.
4. MB=1 with BA pointing to a pending register -> no stall, and B_out=const_in.
5. Same-cycle accept of RW=1, DA=4 and wb_en with wb_addr=4 -> pend[4] remains 1, so a following read of R4 stalls.
6. wb_flags=4'b0110 with wb_en -> flags=4'b0110. Then assert rst_n=0 mid-stall -> out_valid=0, flags=0, all registers read 0, and in_ready=1.
